// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - code constants shared by the registered 4-to-2 priority encoder

package encoder_pkg;

    localparam logic [1:0] CODE_A    = 2'b11;
    localparam logic [1:0] CODE_B    = 2'b10;
    localparam logic [1:0] CODE_C    = 2'b01;
    localparam logic [1:0] CODE_D    = 2'b00;
    localparam logic [1:0] CODE_NONE = 2'b00;

endpackage

// File: rtl/encoder_prio_core.sv
// rtl/encoder_prio_core.sv - combinational a>b>c>d priority logic; multi-hot flag under ENCODER_MULTIHOT_ERR_EN

module encoder_prio_core
    import encoder_pkg::*;
(
    input  logic [3:0] req,
    output logic [1:0] code,
    output logic       any
`ifdef ENCODER_MULTIHOT_ERR_EN
    ,
    output logic       multi
`endif
);

    // req[3] is a (highest priority), req[0] is d
    always_comb begin
        code = CODE_NONE;
        if (req[3]) begin
            code = CODE_A;
        end else if (req[2]) begin
            code = CODE_B;
        end else if (req[1]) begin
            code = CODE_C;
        end else if (req[0]) begin
            code = CODE_D;
        end
    end

    assign any = |req;

`ifdef ENCODER_MULTIHOT_ERR_EN
    assign multi = (req[3] & (req[2] | req[1] | req[0]))
                 | (req[2] & (req[1] | req[0]))
                 | (req[1] & req[0]);
`endif

endmodule

// File: rtl/encoder.sv
// rtl/encoder.sv - registered 4-to-2 priority encoder top; optional err output under ENCODER_MULTIHOT_ERR_EN

module encoder
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e0,
    output logic e1,
    output logic valid
`ifdef ENCODER_MULTIHOT_ERR_EN
    ,
    output logic err
`endif
);

    logic [1:0] code_d, code_q;
    logic       valid_d, valid_q;

`ifdef ENCODER_MULTIHOT_ERR_EN
    logic       err_d, err_q;
`endif

    encoder_prio_core u_core (
        .req   ({a, b, c, d}),
        .code  (code_d),
        .any   (valid_d)
`ifdef ENCODER_MULTIHOT_ERR_EN
        ,
        .multi (err_d)
`endif
    );

    // Reset wins over sampling: the sample at a reset edge is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= CODE_NONE;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef ENCODER_MULTIHOT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign e1    = code_q[1];
    assign e0    = code_q[0];
    assign valid = valid_q;

endmodule

// File: tb/tb_encoder.sv
// tb/tb_encoder.sv - self-checking bench for encoder; checks err when ENCODER_MULTIHOT_ERR_EN is defined

module tb_encoder;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic e0, e1, valid;
`ifdef ENCODER_MULTIHOT_ERR_EN
    logic err;
`endif

    int n_tests;
    int n_fail;

    encoder dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e0    (e0),
        .e1    (e1),
        .valid (valid)
`ifdef ENCODER_MULTIHOT_ERR_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [2:0] exp;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    // Reference: code is the bit position of the highest set request, a at position 3
    function automatic logic [2:0] ref_out(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) idx = 2'(i);
        end
        return {idx, (req != 4'd0)};
    endfunction

    function automatic logic ref_err(input logic [3:0] req);
        return $countones(req) >= 2;
    endfunction

    task automatic check(input string name, input logic [2:0] exp, input logic exp_err);
        n_tests++;
        if ({e1, e0, valid} !== exp) begin
            n_fail++;
            $display("FAIL %s: {e1,e0,valid} got %b expected %b", name, {e1, e0, valid}, exp);
        end
`ifdef ENCODER_MULTIHOT_ERR_EN
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: err got %b expected %b", name, err, exp_err);
        end
`else
        if (exp_err === 1'bx) $display("unexpected x err expectation in %s", name);
`endif
    endtask

    // Drive at negedge, let one rising edge capture, look 1 time unit later
    task automatic apply(input logic [3:0] req, input logic r);
        @(negedge clk);
        {a, b, c, d} = req;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] req;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        {a, b, c, d} = 4'b0000;

        vecs[0] = '{4'b0000, 3'b000, 1'b0};
        vecs[1] = '{4'b0001, 3'b001, 1'b0};
        vecs[2] = '{4'b0010, 3'b011, 1'b0};
        vecs[3] = '{4'b0100, 3'b101, 1'b0};
        vecs[4] = '{4'b1000, 3'b111, 1'b0};
        vecs[5] = '{4'b1001, 3'b111, 1'b1};
        vecs[6] = '{4'b0110, 3'b101, 1'b1};
        vecs[7] = '{4'b0011, 3'b011, 1'b1};
        vecs[8] = '{4'b1111, 3'b111, 1'b1};
        vecs[9] = '{4'b0101, 3'b101, 1'b1};

        // reset held two edges with a high, then release
        apply(4'b1000, 1'b1);
        check("reset_edge1", 3'b000, 1'b0);
        apply(4'b1000, 1'b1);
        check("reset_edge2", 3'b000, 1'b0);
        apply(4'b1000, 1'b0);
        check("reset_release", 3'b111, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].req, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_err);
        end

        // outputs must not move until the edge after the input change
        apply(4'b0000, 1'b0);
        check("lat_pre", 3'b000, 1'b0);
        @(negedge clk);
        {a, b, c, d} = 4'b1000;
        #4;
        check("lat_hold", 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check("lat_edge", 3'b111, 1'b0);

        // reset pulse while b steady
        apply(4'b0100, 1'b0);
        check("rstpulse_pre", 3'b101, 1'b0);
        apply(4'b0100, 1'b1);
        check("rstpulse_edge", 3'b000, 1'b0);
        apply(4'b0100, 1'b0);
        check("rstpulse_after", 3'b101, 1'b0);

        // d-only then all-zero: code stays 00, valid falls
        apply(4'b0001, 1'b0);
        check("donly", 3'b001, 1'b0);
        apply(4'b0000, 1'b0);
        check("zero_after_d", 3'b000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            req = 4'($urandom_range(0, 15));
            apply(req, 1'b0);
            check($sformatf("rand%0d_req%b", i, req), ref_out(req), ref_err(req));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
